// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code set 2 parser feeding a show-ahead key-event FIFO, with a
// held-key bitmap and its registered population count.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH    = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int REQUIRE_INIT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         flush,
  input  logic         ev_ready,
  output logic         ev_valid,
  output logic [8:0]   ev_code,
  output logic         ev_break,
  output logic [511:0] key_down,
  output logic [9:0]   pressed_count,
  output logic         overflow,
  output logic         ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic READY_AT_RESET = (REQUIRE_INIT == 0);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_EXT     = 3'd2,
    ST_BRK     = 3'd3,
    ST_EXT_BRK = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (REQUIRE_INIT != 0) ? ST_INIT : ST_IDLE;

  function automatic logic [9:0] popcount512(input logic [511:0] v);
    logic [9:0] s;
    s = 10'd0;
    for (int i = 0; i < 512; i++) begin
      s = s + {9'd0, v[i]};
    end
    return s;
  endfunction

  state_t         state;
  logic           ext_flag;
  logic           brk_flag;
  logic           key_done;
  logic [8:0]     key_code;
  logic           key_held;
  logic           push;
  logic           pop;
  logic           full;
  logic           accept;
  logic           drop;
  logic [9:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  // Prefix flags are carried in the parser state encoding.
  always_comb begin
    ext_flag = 1'b0;
    brk_flag = 1'b0;
    case (state)
      ST_EXT:     ext_flag = 1'b1;
      ST_BRK:     brk_flag = 1'b1;
      ST_EXT_BRK: begin
        ext_flag = 1'b1;
        brk_flag = 1'b1;
      end
      default: begin
        ext_flag = 1'b0;
        brk_flag = 1'b0;
      end
    endcase
  end

  // Key completion and the repeat/unmatched-break filter decision.
  always_comb begin
    key_done = rx_valid && (state != ST_INIT) &&
               (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
    key_code = {ext_flag, rx_byte};
    key_held = key_down[key_code];
    if (FILTER_REPEAT != 0) begin
      push = key_done && (brk_flag ? key_held : !key_held);
    end else begin
      push = key_done;
    end
  end

  // Queue handshake; a push into an empty queue is never bypassed to the head.
  always_comb begin
    ev_valid = (count != {(AW+1){1'b0}});
    full     = (count == FULL_COUNT);
    pop      = ev_valid && ev_ready;
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    ev_code  = mem[rd_ptr][8:0];
    ev_break = mem[rd_ptr][9];
  end

  // Parser FSM; only advances on qualified bytes, flush does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
      ready <= READY_AT_RESET;
    end else if (rx_valid) begin
      case (state)
        ST_INIT: begin
          if (rx_byte == 8'hAA) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            state <= ST_INIT;
          end
        end
        ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK: begin
          ready <= 1'b1;
          if (rx_byte == 8'hE0) begin
            state <= brk_flag ? ST_EXT_BRK : ST_EXT;
          end else if (rx_byte == 8'hF0) begin
            state <= ext_flag ? ST_EXT_BRK : ST_BRK;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= RESET_STATE;
          ready <= READY_AT_RESET;
        end
      endcase
    end else begin
      state <= state;
    end
  end

  // Held-key bitmap; updates even when the event itself is filtered or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_down <= '0;
    end else if (key_done) begin
      key_down[key_code] <= !brk_flag;
    end else begin
      key_down <= key_down;
    end
  end

  // Count of held keys, one cycle behind the bitmap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_count <= 10'd0;
    end else begin
      pressed_count <= popcount512(key_down);
    end
  end

  // Queue pointers, occupancy and sticky overflow; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end
  end

  // Event storage, {break, code} per entry.
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      mem[wr_ptr] <= {brk_flag, key_code};
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Three differently configured queues share one byte stream; a queue-level
// model predicts every output each cycle, plus literal spot checks.
module tb_ps2_key_event_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic         flush = 1'b0;
  logic         ev_ready = 1'b0;
  logic         ev_valid [3];
  logic [8:0]   ev_code [3];
  logic         ev_break [3];
  logic [511:0] key_down [3];
  logic [9:0]   pressed_count [3];
  logic         overflow [3];
  logic         ready [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue #(.FIFO_DEPTH(4), .FILTER_REPEAT(1), .REQUIRE_INIT(1)) u0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .flush(flush),
    .ev_ready(ev_ready), .ev_valid(ev_valid[0]), .ev_code(ev_code[0]),
    .ev_break(ev_break[0]), .key_down(key_down[0]), .pressed_count(pressed_count[0]),
    .overflow(overflow[0]), .ready(ready[0]));

  ps2_key_event_queue #(.FIFO_DEPTH(4), .FILTER_REPEAT(0), .REQUIRE_INIT(1)) u1 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .flush(flush),
    .ev_ready(ev_ready), .ev_valid(ev_valid[1]), .ev_code(ev_code[1]),
    .ev_break(ev_break[1]), .key_down(key_down[1]), .pressed_count(pressed_count[1]),
    .overflow(overflow[1]), .ready(ready[1]));

  ps2_key_event_queue #(.FIFO_DEPTH(8), .FILTER_REPEAT(1), .REQUIRE_INIT(0)) u2 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .flush(flush),
    .ev_ready(ev_ready), .ev_valid(ev_valid[2]), .ev_code(ev_code[2]),
    .ev_break(ev_break[2]), .key_down(key_down[2]), .pressed_count(pressed_count[2]),
    .overflow(overflow[2]), .ready(ready[2]));

  // Model state per instance: list of pending events, held keys, prefix flags.
  logic [9:0]   mq [3][64];
  int           mcnt [3];
  logic [511:0] mkd [3];
  bit           minit [3];
  bit           mext [3];
  bit           mbrk [3];
  bit           movf [3];
  int           mpc [3];

  function automatic int dep(input int i);
    return (i == 2) ? 8 : 4;
  endfunction
  function automatic bit filt(input int i);
    return (i != 1);
  endfunction
  function automatic bit needs_bat(input int i);
    return (i != 2);
  endfunction
  function automatic int popcnt(input logic [511:0] v);
    int s = 0;
    for (int k = 0; k < 512; k++) s += int'(v[k]);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mkd[i] = '0; mext[i] = 1'b0; mbrk[i] = 1'b0;
      movf[i] = 1'b0; mpc[i] = 0; minit[i] = !needs_bat(i);
    end
  endtask

  // Apply one clock edge's worth of behaviour using the inputs held across it.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit pop, push, held;
        logic [8:0] code;
        logic [9:0] ev;
        int n;
        push = 1'b0;
        ev = 10'd0;
        mpc[i] = popcnt(mkd[i]);
        pop = ev_ready && (mcnt[i] > 0);
        if (rx_valid) begin
          if (!minit[i]) begin
            if (rx_byte == 8'hAA) minit[i] = 1'b1;
          end else if (rx_byte == 8'hE0) begin
            mext[i] = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            mbrk[i] = 1'b1;
          end else begin
            code = {mext[i], rx_byte};
            held = mkd[i][code];
            push = !filt(i) || (mbrk[i] ? held : !held);
            ev = {mbrk[i], code};
            mkd[i][code] = !mbrk[i];
            mext[i] = 1'b0;
            mbrk[i] = 1'b0;
          end
        end
        if (flush) begin
          mcnt[i] = 0;
          movf[i] = 1'b0;
        end else begin
          n = mcnt[i];
          if (pop) begin
            for (int k = 0; k < 63; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
          end
          if (push) begin
            if (n == dep(i) && !pop) movf[i] = 1'b1;
            else begin
              mq[i][mcnt[i]] = ev;
              mcnt[i]++;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int inst, input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("ev_valid", i, ev_valid[i], mcnt[i] > 0);
      if (mcnt[i] > 0) begin
        chk("ev_code", i, ev_code[i], mq[i][0][8:0]);
        chk("ev_break", i, ev_break[i], mq[i][0][9]);
      end
      chk("key_down", i, key_down[i], mkd[i]);
      chk("pressed_count", i, pressed_count[i], mpc[i]);
      chk("overflow", i, overflow[i], movf[i]);
      chk("ready", i, ready[i], minit[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    repeat (10) step();
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int npop [3];
  logic [8:0] kidx;

  initial begin
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    chk("lit_ready_reset", 0, ready[0], 1'b0);
    chk("lit_ready_noinit", 2, ready[2], 1'b1);
    chk("lit_empty_reset", 0, ev_valid[0], 1'b0);
    chk("lit_pcount_reset", 0, pressed_count[0], 10'd0);

    // Bytes before the BAT code are ignored; a reset discards an E0 F0 prefix.
    send(8'h1C);
    chk("lit_pre_bat_ev", 0, ev_valid[0], 1'b0);
    chk("lit_pre_bat_kd", 0, key_down[0], 512'd0);
    send(8'hE0);
    send(8'hF0);
    do_reset();
    send(8'hAA);
    send(8'h1C);
    chk("lit_ready_after_bat", 0, ready[0], 1'b1);
    chk("lit_first_ev_valid", 0, ev_valid[0], 1'b1);
    chk("lit_first_ev_code", 0, ev_code[0], 9'h01C);
    chk("lit_first_ev_break", 0, ev_break[0], 1'b0);
    chk("lit_first_kd", 0, key_down[0][28], 1'b1);
    chk("lit_first_pcount", 0, pressed_count[0], 10'd1);
    chk("lit_aa_as_key_pcount", 2, pressed_count[2], 10'd2);
    drain();

    // Typematic repeats: one event when filtered, three when not.
    send(8'h1A);
    send(8'h1A);
    send(8'h1A);
    for (int i = 0; i < 3; i++) npop[i] = 0;
    ev_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) if (ev_valid[i]) npop[i]++;
      step();
    end
    ev_ready = 1'b0;
    chk("lit_repeat_filtered", 0, npop[0], 1);
    chk("lit_repeat_unfiltered", 1, npop[1], 3);
    chk("lit_repeat_filtered", 2, npop[2], 1);

    // Extended make then extended break.
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    kidx = 9'h175;
    chk("lit_ext_make_code", 0, ev_code[0], 9'h175);
    chk("lit_ext_make_brk", 0, ev_break[0], 1'b0);
    chk("lit_ext_kd_clear", 0, key_down[0][kidx], 1'b0);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    step();
    chk("lit_ext_break_code", 0, ev_code[0], 9'h175);
    chk("lit_ext_break_brk", 0, ev_break[0], 1'b1);
    send(8'hF0);
    send(8'h4D);
    drain();

    // Overflow on a depth-4 queue, then push+pop while full, then flush.
    do_reset();
    send(8'hAA);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    send(8'h2C);
    chk("lit_ovf_set", 0, overflow[0], 1'b1);
    chk("lit_ovf_pcount", 0, pressed_count[0], 10'd5);
    chk("lit_ovf_head", 0, ev_code[0], 9'h015);
    chk("lit_model_full", 0, mcnt[0], 4);
    chk("lit_no_ovf_deep", 2, overflow[2], 1'b0);
    ev_ready = 1'b1;
    rx_byte = 8'h33;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    step();
    chk("lit_full_pushpop_head", 0, ev_code[0], 9'h01D);
    chk("lit_full_pushpop_occ", 0, mcnt[0], 4);
    chk("lit_ovf_sticky", 0, overflow[0], 1'b1);
    ev_ready = 1'b1;
    repeat (3) step();
    ev_ready = 1'b0;
    chk("lit_tail_event", 0, ev_code[0], 9'h033);
    flush = 1'b1;
    rx_byte = 8'h3B;
    rx_valid = 1'b1;
    step();
    flush = 1'b0;
    rx_valid = 1'b0;
    step();
    kidx = 9'h03B;
    chk("lit_flush_empty", 0, ev_valid[0], 1'b0);
    chk("lit_flush_ovf", 0, overflow[0], 1'b0);
    chk("lit_flush_kd_kept", 0, key_down[0][kidx], 1'b1);
    chk("lit_flush_pcount", 0, pressed_count[0], 10'd7);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_queue.md
PS2_KEY_EVENT_QUEUE -- requirements
Module: ps2_key_event_queue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event queue depth (power of 2, 2..64).
REQ-002 SHALL have parameter FILTER_REPEAT, default 1, meaning 1 = suppress typematic repeats and unmatched breaks.
REQ-003 SHALL have parameter REQUIRE_INIT, default 1, meaning 1 = ignore bytes until BAT code 0xAA is received.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port rx_byte, input, 8 bits: scan-code byte from PS/2 receiver.
REQ-007 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_byte.
REQ-008 SHALL have port flush, input, 1 bit: synchronous queue/overflow clear.
REQ-009 SHALL have port ev_ready, input, 1 bit: consumer pops the head event.
REQ-010 SHALL have port ev_valid, output, 1 bit: queue non-empty.
REQ-011 SHALL have port ev_code, output, 9 bits: head event code {extended, byte}.
REQ-012 SHALL have port ev_break, output, 1 bit: head event is a release.
REQ-013 SHALL have port key_down, output, 512 bits: bitmap of held keys, indexed by 9-bit code.
REQ-014 SHALL have port pressed_count, output, 10 bits: number of set bits in key_down.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, event dropped on full queue.
REQ-016 SHALL have port ready, output, 1 bit: parser armed (past INIT).

Function
REQ-017 Parser SHALL have states INIT, IDLE, EXT, BRK, EXT_BRK; it advances only on edges where rx_valid=1.
REQ-018 In INIT, 0xAA SHALL move the parser to IDLE; all other bytes are ignored; with REQUIRE_INIT=0 the reset state SHALL be IDLE.
REQ-019 In any non-INIT state, 0xE0 SHALL set the extended flag (IDLE->EXT, BRK->EXT_BRK) and 0xF0 SHALL set the break flag (IDLE->BRK, EXT->EXT_BRK).
REQ-020 In any non-INIT state, any other byte SHALL complete a key with code = {ext, rx_byte} and break = brk, and SHALL return the parser to IDLE.
REQ-021 A completed make SHALL set key_down[code]; a completed break SHALL clear it; the update SHALL occur on the same edge that samples the final byte.
REQ-022 With FILTER_REPEAT=1, a make of a key already held and a break of a key not held SHALL NOT enqueue an event (key_down unchanged); with FILTER_REPEAT=0, every completed key SHALL enqueue.
REQ-023 An enqueued event SHALL be written on the sampling edge and SHALL be visible at the ev_* outputs no earlier than the following cycle (show-ahead FIFO, 1-cycle latency).
REQ-024 Pop SHALL occur on an edge with ev_valid=1 and ev_ready=1; ev_ready while empty SHALL be ignored.
REQ-025 Push while full without a same-cycle pop SHALL drop the event and set overflow; key_down SHALL still update.
REQ-026 Push and pop in the same cycle while full SHALL both succeed, and occupancy SHALL stay at FIFO_DEPTH.
REQ-027 Push on an empty queue with ev_ready=1 SHALL NOT bypass; the event SHALL appear in the next cycle.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH, using a log2(FIFO_DEPTH)+1-bit occupancy count.
REQ-029 flush SHALL empty the queue and clear overflow on the next edge, override a same-cycle push/pop, and leave key_down and the parser unchanged.
REQ-030 pressed_count SHALL be registered, equal popcount(key_down) one cycle after any key_down change, and never exceed 512.
REQ-031 0xAA received in a non-INIT state SHALL be treated as an ordinary key byte.

Reset
REQ-032 On rst: parser to INIT (IDLE if REQUIRE_INIT=0); ext/brk flags, key_down, pressed_count, overflow, and queue pointers to 0; ev_valid=0; ready=0 (1 if REQUIRE_INIT=0).
REQ-033 rst asserted mid-sequence (e.g. after E0 F0) SHALL discard the partial code; no event SHALL be generated after release.

Verification
REQ-034 Bytes AA, 1C -> ready=1; event {0x01C, make}; key_down[0x01C]=1; pressed_count=1.
REQ-035 Bytes AA, E0, 75, E0, F0, 75 -> events {0x175, make} then {0x175, break}; key_down[0x175]=0 at the end.
REQ-036 FILTER_REPEAT=1, bytes AA, 1C, 1C, 1C -> exactly one event; with FILTER_REPEAT=0 -> three events.
REQ-037 FIFO_DEPTH=4, ev_ready=0, five distinct makes -> 4 events queued, overflow=1, pressed_count=5; then flush -> ev_valid=0, overflow=0, key_down retained.
REQ-038 Full queue with a push and ev_ready=1 on the same edge -> occupancy stays 4; the oldest event is popped and the new event is at the tail.
REQ-039 REQUIRE_INIT=1, byte 1C before AA -> no event, key_down=0; rst after E0 F0, then AA, 1C -> event {0x01C, make}.
